// File: rtl/register_tree_kv.sv
// register_tree_kv: key/value priority queue held in unsorted flat slots.
// A comparator tree, registered one level per cycle, picks the top entry.
// Outputs hold their last settled value while the tree is recomputing.
module register_tree_kv #(
  parameter int   QUEUE_SIZE = 15,
  parameter int   KEY_WIDTH  = 16,
  parameter int   VAL_WIDTH  = 8,
  parameter logic MIN_FIRST  = 1'b0,
  parameter logic ENQ_ENA    = 1'b1
) (
  input  logic                               i_CLK,
  input  logic                               i_RSTn,
  input  logic                               i_wrt,
  input  logic                               i_read,
  input  logic [KEY_WIDTH-1:0]               i_key,
  input  logic [VAL_WIDTH-1:0]               i_val,
  output logic                               o_full,
  output logic                               o_empty,
  output logic                               o_busy,
  output logic [KEY_WIDTH-1:0]               o_key,
  output logic [VAL_WIDTH-1:0]               o_val,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]    o_count,
  output logic                               o_drop
);

  localparam int LEVELS = ($clog2(QUEUE_SIZE) < 1) ? 1 : $clog2(QUEUE_SIZE);
  localparam int CW     = $clog2(QUEUE_SIZE + 1);
  localparam int LEAVES = 1 << LEVELS;
  localparam int NINT   = LEAVES - 1;      // internal nodes, index 0 is the root
  localparam int NODES  = 2 * LEAVES - 1;  // heap layout: children of n are 2n+1, 2n+2

  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
    logic [LEVELS-1:0]    idx;
  } node_t;

  // Left operand always covers lower slot indices, so ties keep it.
  function automatic node_t pick(node_t a, node_t b);
    logic a_wins;
    if (!a.vld) return b;
    if (!b.vld) return a;
    a_wins = MIN_FIRST ? (a.key <= b.key) : (a.key >= b.key);
    return a_wins ? a : b;
  endfunction

  logic [KEY_WIDTH-1:0] slot_key [QUEUE_SIZE];
  logic [VAL_WIDTH-1:0] slot_val [QUEUE_SIZE];
  logic [CW-1:0]        count;
  logic [CW-1:0]        last;
  logic [LEVELS-1:0]    top_idx;
  logic [LEVELS:1]      vld_pipe;
  node_t                tree_q [NINT];
  node_t                leaf   [LEAVES];
  node_t                nd     [NODES];
  node_t                root;
  logic [KEY_WIDTH-1:0] mv_key;
  logic [VAL_WIDTH-1:0] mv_val;
  logic                 req, do_enq, do_rep, do_deq, accept;

  assign o_count = count;
  assign o_full  = (count == CW'(QUEUE_SIZE));
  assign o_empty = (count == '0);
  assign o_busy  = |vld_pipe;
  assign last    = count - 1'b1;

  // Replace on an empty queue is an enqueue and ignores ENQ_ENA.
  assign req    = i_wrt | i_read;
  assign do_enq = ~o_busy & i_wrt & ((~i_read & ENQ_ENA & ~o_full) | (i_read & o_empty));
  assign do_rep = ~o_busy & i_wrt & i_read & ~o_empty;
  assign do_deq = ~o_busy & ~i_wrt & i_read & ~o_empty;
  assign accept = do_enq | do_rep | do_deq;

  // Leaves: one per slot, padding leaves are permanently invalid.
  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < QUEUE_SIZE) begin : g_real
      assign leaf[gi] = '{vld: (CW'(gi) < count), key: slot_key[gi],
                          val: slot_val[gi], idx: LEVELS'(gi)};
    end else begin : g_pad
      assign leaf[gi] = '0;
    end
  end

  // Flatten registered internal nodes and leaves into one heap array.
  always_comb begin
    for (int n = 0; n < NINT; n++) nd[n] = tree_q[n];
    for (int i = 0; i < LEAVES; i++) nd[NINT+i] = leaf[i];
  end

  // Last tree level is combinational and lands directly in the output register.
  assign root = pick(nd[1], nd[2]);

  // Entry being moved into the vacated top slot on dequeue.
  always_comb begin
    mv_key = '0;
    mv_val = '0;
    for (int i = 0; i < QUEUE_SIZE; i++)
      if (CW'(i) == last) begin
        mv_key = slot_key[i];
        mv_val = slot_val[i];
      end
  end

  // Slot storage, occupancy and drop pulse.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      count  <= '0;
      o_drop <= 1'b0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        slot_key[i] <= '0;
        slot_val[i] <= '0;
      end
    end else begin
      o_drop <= req & ~accept;
      if (do_enq)      count <= count + 1'b1;
      else if (do_deq) count <= count - 1'b1;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (do_enq && CW'(i) == count) begin
          slot_key[i] <= i_key;
          slot_val[i] <= i_val;
        end
        if (do_rep && LEVELS'(i) == top_idx) begin
          slot_key[i] <= i_key;
          slot_val[i] <= i_val;
        end
        if (do_deq) begin
          if (LEVELS'(i) == top_idx) begin
            slot_key[i] <= mv_key;
            slot_val[i] <= mv_val;
          end
          // Clear after the move so removing the last slot leaves zeros.
          if (CW'(i) == last) begin
            slot_key[i] <= '0;
            slot_val[i] <= '0;
          end
        end
      end
    end
  end

  // Free-running tree levels; storage is frozen while busy so each level settles in turn.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int n = 0; n < NINT; n++) tree_q[n] <= '0;
    end else begin
      for (int n = 0; n < NINT; n++) tree_q[n] <= pick(nd[2*n+1], nd[2*n+2]);
    end
  end

  // Busy shift register; outputs update only when the root is final.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      vld_pipe <= '0;
      o_key    <= '0;
      o_val    <= '0;
      top_idx  <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int k = 2; k <= LEVELS; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (vld_pipe[LEVELS]) begin
        o_key   <= root.vld ? root.key : '0;
        o_val   <= root.vld ? root.val : '0;
        top_idx <= root.vld ? root.idx : '0;
      end
    end
  end

endmodule

// File: tb/tb_register_tree_kv.sv
// Directed-table plus randomized bench for register_tree_kv (QUEUE_SIZE=7, 8-bit key/val).
// Instance 0: max-first; instance 1: min-first; instance 2: plain enqueue disabled.
module tb_register_tree_kv;

  localparam int QS = 7;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wrt [3];
  logic       rd  [3];
  logic [7:0] key_i [3];
  logic [7:0] val_i [3];
  logic       full [3], empty [3], busy [3], drop [3];
  logic [7:0] okey [3], oval [3];
  logic [2:0] ocnt [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_tree_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b0), .ENQ_ENA(1'b1)) u0 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt[0]), .i_read(rd[0]), .i_key(key_i[0]), .i_val(val_i[0]),
    .o_full(full[0]), .o_empty(empty[0]), .o_busy(busy[0]), .o_key(okey[0]), .o_val(oval[0]),
    .o_count(ocnt[0]), .o_drop(drop[0]));
  register_tree_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b1), .ENQ_ENA(1'b1)) u1 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt[1]), .i_read(rd[1]), .i_key(key_i[1]), .i_val(val_i[1]),
    .o_full(full[1]), .o_empty(empty[1]), .o_busy(busy[1]), .o_key(okey[1]), .o_val(oval[1]),
    .o_count(ocnt[1]), .o_drop(drop[1]));
  register_tree_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(8), .VAL_WIDTH(8), .MIN_FIRST(1'b0), .ENQ_ENA(1'b0)) u2 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(wrt[2]), .i_read(rd[2]), .i_key(key_i[2]), .i_val(val_i[2]),
    .o_full(full[2]), .o_empty(empty[2]), .o_busy(busy[2]), .o_key(okey[2]), .o_val(oval[2]),
    .o_count(ocnt[2]), .o_drop(drop[2]));

  typedef struct {
    logic       w, r;
    logic [7:0] k, v;
    int         ebusy;
    logic       edrop;
    logic [7:0] ek, ev;
    int         ecnt;
    logic       efull, eempty;
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mk(logic w, logic r, logic [7:0] k, logic [7:0] v, int eb, logic ed,
                              logic [7:0] ek, logic [7:0] ev, int ec, logic ef, logic ee);
    vec_t t;
    t.w = w; t.r = r; t.k = k; t.v = v; t.ebusy = eb; t.edrop = ed;
    t.ek = ek; t.ev = ev; t.ecnt = ec; t.efull = ef; t.eempty = ee;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Issue one request on instance d, then run until the tree is idle (bounded).
  // Returns busy cycles seen, the drop flag in the following cycle, and whether
  // o_key/o_val held their old value throughout the busy window.
  task automatic op(input int d, input logic w, input logic r, input logic [7:0] k, input logic [7:0] v,
                    output int nbusy, output logic dseen, output logic held);
    logic [7:0] pk, pv;
    @(negedge clk);
    pk = okey[d]; pv = oval[d];
    wrt[d] = w; rd[d] = r; key_i[d] = k; val_i[d] = v;
    @(negedge clk);
    wrt[d] = 1'b0; rd[d] = 1'b0;
    dseen = drop[d];
    nbusy = 0;
    held  = 1'b1;
    while (busy[d] && nbusy < 10) begin
      if (okey[d] !== pk || oval[d] !== pv) held = 1'b0;
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string nm, input int d, input logic w, input logic r,
                          input logic [7:0] k, input logic [7:0] v, input int eb, input logic ed,
                          input logic [7:0] ek, input logic [7:0] ev, input int ec);
    int nb; logic ds, hd;
    op(d, w, r, k, v, nb, ds, hd);
    chk({nm, " busy"}, nb, eb);
    chk({nm, " drop"}, int'(ds), int'(ed));
    chk({nm, " hold"}, int'(hd), 1);
    chk({nm, " key"}, int'(okey[d]), int'(ek));
    chk({nm, " val"}, int'(oval[d]), int'(ev));
    chk({nm, " count"}, int'(ocnt[d]), ec);
  endtask

  // Reference model state for the randomized run (instance 0, max-first).
  int mk_k [QS];
  int mk_v [QS];
  int mcnt;

  function automatic int mtop();
    int t = 0;
    for (int i = 1; i < mcnt; i++) if (mk_k[i] > mk_k[t]) t = i;
    return t;
  endfunction

  initial begin
    int nb; logic ds, hd;
    for (int d = 0; d < 3; d++) begin
      wrt[d] = 1'b0; rd[d] = 1'b0; key_i[d] = '0; val_i[d] = '0;
    end

    // Slot contents after each row were worked through by hand.
    tv[0]  = mk(1,0,8'd5,8'hA0, LV,0, 8'd5,8'hA0, 1, 0,0);
    tv[1]  = mk(1,0,8'd9,8'hA1, LV,0, 8'd9,8'hA1, 2, 0,0);
    tv[2]  = mk(1,0,8'd9,8'hA2, LV,0, 8'd9,8'hA1, 3, 0,0);
    tv[3]  = mk(1,0,8'd2,8'hA3, LV,0, 8'd9,8'hA1, 4, 0,0);
    tv[4]  = mk(1,0,8'd7,8'hB0, LV,0, 8'd9,8'hA1, 5, 0,0);
    tv[5]  = mk(1,0,8'd1,8'hB1, LV,0, 8'd9,8'hA1, 6, 0,0);
    tv[6]  = mk(1,0,8'd3,8'hB2, LV,0, 8'd9,8'hA1, 7, 1,0);
    tv[7]  = mk(1,0,8'd8,8'hB3, 0, 1, 8'd9,8'hA1, 7, 1,0);
    tv[8]  = mk(0,1,8'd0,8'h00, LV,0, 8'd9,8'hA2, 6, 0,0);
    tv[9]  = mk(0,1,8'd0,8'h00, LV,0, 8'd7,8'hB0, 5, 0,0);
    tv[10] = mk(0,1,8'd0,8'h00, LV,0, 8'd5,8'hA0, 4, 0,0);
    tv[11] = mk(0,1,8'd0,8'h00, LV,0, 8'd3,8'hB2, 3, 0,0);
    tv[12] = mk(0,1,8'd0,8'h00, LV,0, 8'd2,8'hA3, 2, 0,0);
    tv[13] = mk(0,1,8'd0,8'h00, LV,0, 8'd1,8'hB1, 1, 0,0);
    tv[14] = mk(0,1,8'd0,8'h00, LV,0, 8'd0,8'h00, 0, 0,1);
    tv[15] = mk(0,1,8'd0,8'h00, 0, 1, 8'd0,8'h00, 0, 0,1);

    // Reset values while reset is held.
    #1;
    chk("rst key",   int'(okey[0]), 0);
    chk("rst val",   int'(oval[0]), 0);
    chk("rst count", int'(ocnt[0]), 0);
    chk("rst empty", int'(empty[0]), 1);
    chk("rst full",  int'(full[0]), 0);
    chk("rst busy",  int'(busy[0]), 0);
    chk("rst drop",  int'(drop[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      check_op(nm, 0, tv[i].w, tv[i].r, tv[i].k, tv[i].v, tv[i].ebusy, tv[i].edrop,
               tv[i].ek, tv[i].ev, tv[i].ecnt);
      chk({nm, " full"},  int'(full[0]),  int'(tv[i].efull));
      chk({nm, " empty"}, int'(empty[0]), int'(tv[i].eempty));
    end

    // Request during busy is rejected and leaves state alone.
    @(negedge clk);
    wrt[0] = 1'b1; rd[0] = 1'b0; key_i[0] = 8'd6; val_i[0] = 8'hC0;
    @(negedge clk);
    chk("bsy first busy", int'(busy[0]), 1);
    chk("bsy first drop", int'(drop[0]), 0);
    key_i[0] = 8'd4; val_i[0] = 8'hC1;
    @(negedge clk);
    wrt[0] = 1'b0;
    chk("bsy reject drop", int'(drop[0]), 1);
    nb = 0;
    while (busy[0] && nb < 10) begin nb++; @(negedge clk); end
    chk("bsy settle", int'(busy[0]), 0);
    chk("bsy key",   int'(okey[0]), 6);
    chk("bsy val",   int'(oval[0]), 8'hC0);
    chk("bsy count", int'(ocnt[0]), 1);
    check_op("bsy deq",   0, 0, 1, 8'd0, 8'd0, LV, 0, 8'd0, 8'd0, 0);
    check_op("empty deq", 0, 0, 1, 8'd0, 8'd0, 0,  1, 8'd0, 8'd0, 0);

    // Min-first ordering and replace of the top entry.
    check_op("min e40", 1, 1, 0, 8'd40, 8'h01, LV, 0, 8'd40, 8'h01, 1);
    check_op("min e3",  1, 1, 0, 8'd3,  8'h02, LV, 0, 8'd3,  8'h02, 2);
    check_op("min e17", 1, 1, 0, 8'd17, 8'h03, LV, 0, 8'd3,  8'h02, 3);
    check_op("min rep", 1, 1, 1, 8'd50, 8'h04, LV, 0, 8'd17, 8'h03, 3);

    // Enqueue disabled: only replace-on-empty can insert.
    check_op("ena enq", 2, 1, 0, 8'd8, 8'h55, 0,  1, 8'd0, 8'h00, 0);
    check_op("ena rep", 2, 1, 1, 8'd8, 8'h55, LV, 0, 8'd8, 8'h55, 1);
    check_op("ena deq", 2, 0, 1, 8'd0, 8'h00, LV, 0, 8'd0, 8'h00, 0);
    chk("ena empty", int'(empty[2]), 1);

    // Reset in the middle of a recompute.
    check_op("mid e44", 0, 1, 0, 8'h44, 8'h11, LV, 0, 8'h44, 8'h11, 1);
    @(negedge clk);
    wrt[0] = 1'b1; key_i[0] = 8'h33; val_i[0] = 8'h22;
    @(negedge clk);
    wrt[0] = 1'b0;
    chk("mid busy before", int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid busy",  int'(busy[0]), 0);
    chk("mid count", int'(ocnt[0]), 0);
    chk("mid empty", int'(empty[0]), 1);
    chk("mid key",   int'(okey[0]), 0);
    chk("mid val",   int'(oval[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the reference model.
    mcnt = 0;
    for (int i = 0; i < QS; i++) begin mk_k[i] = 0; mk_v[i] = 0; end
    for (int n = 0; n < 200; n++) begin
      int sel, k, v, t, ek, ev;
      logic w, r, acc;
      string nm;
      sel = $urandom_range(0, 5);
      k = $urandom_range(0, 15);
      v = $urandom_range(0, 255);
      w = (sel != 3 && sel != 4);
      r = (sel >= 3);
      acc = 1'b1;
      t = mtop();
      if (w && !r) begin
        if (mcnt == QS) acc = 1'b0;
        else begin mk_k[mcnt] = k; mk_v[mcnt] = v; mcnt++; end
      end else if (!w && r) begin
        if (mcnt == 0) acc = 1'b0;
        else begin
          mk_k[t] = mk_k[mcnt-1]; mk_v[t] = mk_v[mcnt-1];
          mcnt--;
          mk_k[mcnt] = 0; mk_v[mcnt] = 0;
        end
      end else begin
        if (mcnt == 0) begin mk_k[0] = k; mk_v[0] = v; mcnt = 1; end
        else begin mk_k[t] = k; mk_v[t] = v; end
      end
      if (mcnt == 0) begin ek = 0; ev = 0; end
      else begin t = mtop(); ek = mk_k[t]; ev = mk_v[t]; end
      nm = $sformatf("rnd%0d", n);
      check_op(nm, 0, w, r, 8'(k), 8'(v), acc ? LV : 0, ~acc, 8'(ek), 8'(ev), mcnt);
      chk({nm, " full"}, int'(full[0]), int'(mcnt == QS));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
